// File: rtl/load_store_queue.sv
// Load/store queue: circular buffer of memory ops, issued strictly in program
// order from the head, with CDB operand wake-up and one address add per cycle.
module load_store_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 disp_valid,
    input  logic                 disp_store,
    input  logic [1:0]           disp_size,
    input  logic                 disp_signed,
    input  logic [ROB_TAG_W-1:0] disp_tag,
    input  logic [DATA_W-1:0]    disp_imm,
    input  logic [DATA_W-1:0]    disp_v1,
    input  logic [DATA_W-1:0]    disp_v2,
    input  logic [ROB_TAG_W-1:0] disp_q1,
    input  logic [ROB_TAG_W-1:0] disp_q2,
    input  logic [ROB_TAG_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic [ROB_TAG_W-1:0] commit_tag,
    output logic                 full,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_done,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 res_valid,
    output logic [ROB_TAG_W-1:0] res_tag,
    output logic [DATA_W-1:0]    res_value
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, LD_WAIT, ST_COMMIT, ST_WAIT, DRAIN} state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [DEPTH-1:0]     busy_q, addr_rdy_q, cmt_q, store_q, sign_q;
    logic [1:0]           size_q [DEPTH];
    logic [ROB_TAG_W-1:0] tag_q  [DEPTH];
    logic [ROB_TAG_W-1:0] q1_q   [DEPTH];
    logic [ROB_TAG_W-1:0] q2_q   [DEPTH];
    logic [DATA_W-1:0]    imm_q  [DEPTH];
    logic [DATA_W-1:0]    v1_q   [DEPTH];
    logic [DATA_W-1:0]    v2_q   [DEPTH];
    logic [DATA_W-1:0]    addr_q [DEPTH];

    logic                 head_busy, ld_issue, st_report, st_commit, deq, enq;
    logic                 cdb_hit1, cdb_hit2;
    logic                 agen_valid;
    logic [PTR_W-1:0]     agen_idx, scan_idx;

    function automatic logic [DATA_W-1:0] load_ext(input logic [1:0] sz, input logic sgn,
                                                   input logic [DATA_W-1:0] raw);
        case (sz)
            2'd0:    return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            2'd1:    return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_busy = (count_q != '0) && busy_q[head_q];
    assign ld_issue  = (state_q == IDLE) && head_busy && !store_q[head_q] && addr_rdy_q[head_q] && !flush;
    assign st_report = (state_q == IDLE) && head_busy && store_q[head_q] && addr_rdy_q[head_q]
                       && (q2_q[head_q] == '0) && !flush;
    assign st_commit = (state_q == ST_COMMIT) && (commit_tag != '0) && (commit_tag == tag_q[head_q]) && !flush;
    assign deq       = ((state_q == LD_WAIT) && mem_done && !flush) || ((state_q == ST_WAIT) && mem_done);
    assign enq       = disp_valid && !full && !flush;
    assign cdb_hit1  = (cdb_tag != '0) && (disp_q1 == cdb_tag);
    assign cdb_hit2  = (cdb_tag != '0) && (disp_q2 == cdb_tag);

    // Pick the oldest entry whose base is ready but has no address yet.
    always_comb begin
        agen_valid = 1'b0;
        agen_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!agen_valid && (CNT_W'(i) < count_q) && busy_q[scan_idx]
                && (q1_q[scan_idx] == '0) && !addr_rdy_q[scan_idx]) begin
                agen_valid = 1'b1;
                agen_idx   = scan_idx;
            end
        end
    end

    // Next head/tail/count; flush keeps only a committed store still in flight.
    always_comb begin
        head_d  = deq ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        if (flush) begin
            if ((state_q == ST_WAIT) && !mem_done) begin
                tail_d  = head_q + PTR_W'(1);
                count_d = CNT_W'(1);
            end else begin
                tail_d  = head_d;
                count_d = '0;
            end
        end
    end

    // Entry storage: enqueue, CDB wake-up, address generation, commit and retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            addr_rdy_q <= '0;
            cmt_q      <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy_q     <= busy_q & cmt_q;
                addr_rdy_q <= addr_rdy_q & cmt_q;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    q1_q[i] <= '0;
                    q2_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (busy_q[i] && (cdb_tag != '0) && (q1_q[i] == cdb_tag)) begin
                        v1_q[i] <= cdb_value;
                        q1_q[i] <= '0;
                    end
                    if (busy_q[i] && (cdb_tag != '0) && (q2_q[i] == cdb_tag)) begin
                        v2_q[i] <= cdb_value;
                        q2_q[i] <= '0;
                    end
                end
                if (agen_valid) begin
                    addr_q[agen_idx]     <= v1_q[agen_idx] + imm_q[agen_idx];
                    addr_rdy_q[agen_idx] <= 1'b1;
                end
                if (st_commit) cmt_q[head_q] <= 1'b1;
                if (enq) begin
                    busy_q[tail_q]     <= 1'b1;
                    addr_rdy_q[tail_q] <= 1'b0;
                    cmt_q[tail_q]      <= 1'b0;
                    store_q[tail_q]    <= disp_store;
                    sign_q[tail_q]     <= disp_signed;
                    size_q[tail_q]     <= disp_size;
                    tag_q[tail_q]      <= disp_tag;
                    imm_q[tail_q]      <= disp_imm;
                    v1_q[tail_q]       <= cdb_hit1 ? cdb_value : disp_v1;
                    q1_q[tail_q]       <= cdb_hit1 ? '0 : disp_q1;
                    v2_q[tail_q]       <= cdb_hit2 ? cdb_value : disp_v2;
                    q2_q[tail_q]       <= cdb_hit2 ? '0 : disp_q2;
                end
            end
            if (deq) begin
                busy_q[head_q]     <= 1'b0;
                addr_rdy_q[head_q] <= 1'b0;
                cmt_q[head_q]      <= 1'b0;
            end
        end
    end

    // Head-of-queue FSM with registered memory and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_value <= '0;
        end else if (rdy) begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mem_req   <= 1'b0;
            res_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_issue) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_size <= size_q[head_q];
                        mem_addr <= addr_q[head_q];
                        state_q  <= LD_WAIT;
                    end else if (st_report) begin
                        res_valid <= 1'b1;
                        res_tag   <= tag_q[head_q];
                        res_value <= addr_q[head_q];
                        state_q   <= ST_COMMIT;
                    end
                end
                LD_WAIT: begin
                    if (mem_done) begin
                        if (!flush) begin
                            res_valid <= 1'b1;
                            res_tag   <= tag_q[head_q];
                            res_value <= load_ext(size_q[head_q], sign_q[head_q], mem_rdata);
                        end
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                ST_COMMIT: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (st_commit) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_size  <= size_q[head_q];
                        mem_addr  <= addr_q[head_q];
                        mem_wdata <= v2_q[head_q];
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: if (mem_done) state_q <= IDLE;
                // A flush while draining leaves the outstanding access to be swallowed.
                DRAIN:   if (mem_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, entry count (power of 2, >=2); ROB_TAG_W, default 4, ROB tag width (tag 0 = none); DATA_W, fixed 32, data/address width.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  rdy  in  1  global enable; all state frozen when 0.
  flush  in  1  misprediction flush.
  disp_valid  in  1  dispatch strobe.
  disp_store  in  1  1 = store, 0 = load.
  disp_size  in  2  0 = byte, 1 = half, 2 = word.
  disp_signed  in  1  load sign-extend.
  disp_tag  in  ROB_TAG_W  destination ROB tag.
  disp_imm, disp_v1, disp_v2  in  32 each  offset, base, store data.
  disp_q1, disp_q2  in  ROB_TAG_W each  producer tags (0 = value ready).
  cdb_tag  in  ROB_TAG_W  broadcast tag (0 = none).
  cdb_value  in  32  broadcast value.
  commit_tag  in  ROB_TAG_W  ROB commits the store with this tag (0 = none).
  full  out  1  no free entry.
  mem_req  out  1  one-cycle memory request pulse.
  mem_we  out  1  write request.
  mem_size  out  2  access size.
  mem_addr  out  32  address.
  mem_wdata  out  32  store data.
  mem_done  in  1  access complete.
  mem_rdata  in  32  raw load data, LSB-aligned.
  res_valid  out  1  one-cycle result pulse to ROB/CDB.
  res_tag  out  ROB_TAG_W  result tag.
  res_value  out  32  load data, or store address on store-ready report.

Function
REQ-003 SHALL hold entries in a circular queue: head, tail, and a count of width log2(DEPTH)+1; pointers wrap DEPTH-1 -> 0.
REQ-004 SHALL drive full = (count == DEPTH); dispatch while full is ignored; a simultaneous dequeue does not unblock the same cycle.
REQ-005 SHALL enqueue at tail when disp_valid and not full; a dispatch operand whose tag equals a nonzero cdb_tag in the same cycle is captured as ready with cdb_value.
REQ-006 SHALL, each cycle, replace every busy entry's q1/q2 that matches a nonzero cdb_tag with cdb_value and clear it.
REQ-007 SHALL compute address = v1 + imm (mod 2^32) for at most one entry per cycle: the oldest busy entry from head with q1 == 0 and no address yet; the address is usable next cycle.
REQ-008 SHALL process only the head entry (strict program order) via FSM IDLE, LD_WAIT, ST_COMMIT, ST_WAIT, DRAIN.
REQ-009 IDLE, head load with address ready: pulse mem_req, mem_we=0, size/addr; -> LD_WAIT.
REQ-010 LD_WAIT, on mem_done: byte/half sign- or zero-extended per disp_signed, word passed through; pulse res_valid/res_tag/res_value; dequeue; -> IDLE.
REQ-011 IDLE, head store with address ready and q2 == 0: pulse res_valid with res_value = address; -> ST_COMMIT.
REQ-012 ST_COMMIT, on commit_tag equal to the head tag: pulse mem_req, mem_we=1, mem_wdata = v2; mark head committed; -> ST_WAIT. commit_tag matching nothing is ignored.
REQ-013 ST_WAIT, on mem_done: dequeue; -> IDLE; no res_valid.
REQ-014 mem_req and res_valid SHALL be single-cycle pulses; one memory access is outstanding at most.
REQ-015 flush SHALL drop all uncommitted entries and clear operand tags; if in ST_WAIT, the committed head survives (count = 1) and completes; if in LD_WAIT, -> DRAIN, which swallows the next mem_done without res_valid and then -> IDLE; otherwise -> IDLE, count = 0. Dispatch and CDB in the flush cycle are ignored.
REQ-016 SHALL freeze all state and hold outputs when rdy = 0; mem_done arriving while rdy = 0 is the memory's responsibility to hold.

Reset
REQ-017 rst SHALL clear head, tail, count, and all busy, address-ready and committed flags; FSM to IDLE; mem_req, mem_we, res_valid, full to 0; mem_size, mem_addr, mem_wdata, res_tag, res_value to 0.
REQ-018 rst SHALL take priority over rdy and flush, mid-access included; a later stale mem_done in IDLE is ignored.

Verification
REQ-019 Load: dispatch LB, v1 = 0x100, imm = 4, q1 = 0; mem_rdata = 0x80 -> mem_req with addr 0x104, size 0; res_value = 0xFFFFFF80 (LBU: 0x00000080).
REQ-020 Store: SW tag 3, v1 = 0x200, v2 = 0xDEADBEEF -> res_valid tag 3, value 0x200; no mem_req until commit_tag = 3; then mem_we = 1, wdata 0xDEADBEEF.
REQ-021 Wake-up: LW with q1 = 5; cdb_tag = 5, value 0x40, in the same cycle as the dispatch -> address 0x40 + imm, request issued with no extra stall.
REQ-022 Full/wrap: DEPTH dispatches -> full = 1, extra dispatch dropped; drain all -> full = 0; DEPTH + 3 further operations wrap pointers correctly.
REQ-023 Flush: flush in LD_WAIT -> following mem_done gives no res_valid; flush in ST_WAIT -> store completes, count 1 -> 0.
REQ-024 Reset mid-load: rst in LD_WAIT -> all outputs 0, count 0, later mem_done ignored.
